d_mem_responder: RTL and testbench



---
 rtl/d_mem_responder_pkg.sv | 13 +
 rtl/d_mem_array.sv | 22 ++
 rtl/d_mem_responder.sv | 115 +++++++++++
 tb/tb_d_mem_responder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its word array.
package d_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] ZERO_DATA  = 32'h0;

endpackage

// File: rtl/d_mem_array.sv
// Word-wide storage with synchronous write and registered (synchronous) read.
module d_mem_array #(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // Contents are deliberately not reset; rdata only changes on a read strobe.
    always_ff @(posedge clock) begin
        if (wr_en) mem[idx] <= wdata;
        if (rd_en) rdata <= mem[idx];
    end

endmodule

// File: rtl/d_mem_responder.sv
// Multi-cycle data-memory responder: one outstanding word request, fixed wait states,
// read data or write acknowledgement returned over a held response channel.
module d_mem_responder
    import d_mem_responder_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [1:0]  fsm_state
);

    // Handshakes: a request transfers on an edge where req_valid && req_ready; a
    // response transfers on an edge where resp_valid && resp_ready. Both sides hold
    // their payload stable while valid is high and the transfer has not happened.

    localparam int                  OFS_W     = $clog2(WORD_BYTES);
    localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]          WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic [31-OFS_W:0]   DEPTH_W   = (32 - OFS_W)'(DEPTH);

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
            $error("d_mem_responder: WAIT_STATES must be in 0..15");
        end
    endgenerate

    state_t      state, state_next;
    logic [3:0]  count;
    logic        cap_write;
    logic [31:0] cap_addr, cap_wdata;
    logic        err_q, rd_sel;
    logic        addr_err, entry;
    logic [31:0] arr_rdata;

    assign addr_err = (cap_addr[OFS_W-1:0] != '0) || (cap_addr[31:OFS_W] >= DEPTH_W);
    // The counter is loaded with WAIT_STATES so the memory access lands on edge
    // N+WAIT_STATES+1 after acceptance at edge N, for every legal setting including 0.
    assign entry    = (state == ST_WAIT) && (count == 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req_valid)        state_next = ST_WAIT;
            ST_WAIT: if (count == 4'd0)    state_next = ST_RESP;
            ST_RESP: if (resp_ready)       state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        resp_error = err_q;
        resp_rdata = rd_sel ? arr_rdata : ZERO_DATA;
        fsm_state  = state;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= 4'd0;
            cap_write <= 1'b0;
            cap_addr  <= ZERO_DATA;
            cap_wdata <= ZERO_DATA;
            err_q     <= 1'b0;
            rd_sel    <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                cap_write <= req_write;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                count     <= WAIT_LOAD;
            end else if (state == ST_WAIT && count != 4'd0) begin
                count <= count - 4'd1;
            end

            if (entry) begin
                err_q  <= addr_err;
                rd_sel <= !cap_write && !addr_err;
            end else if (state == ST_RESP && resp_ready) begin
                err_q  <= 1'b0;
                rd_sel <= 1'b0;
            end
        end
    end

    // Writes commit only on the entry edge, so a reset during WAIT drops them.
    d_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clock (clock),
        .wr_en (entry && cap_write && !addr_err),
        .rd_en (entry && !cap_write && !addr_err),
        .idx   (cap_addr[IDX_W+OFS_W-1:OFS_W]),
        .wdata (cap_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_d_mem_responder.sv
// Randomized scoreboard bench for d_mem_responder (WAIT_STATES=2) plus a WAIT_STATES=0 instance.
module tb_d_mem_responder;

    localparam int DEPTH = 64;
    localparam int WS    = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid = 1'b0, req_write = 1'b0, req_ready;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_ready = 1'b1, resp_error;
    logic [31:0] resp_rdata;
    logic [1:0]  fsm_state;

    logic        req_valid0 = 1'b0, req_write0 = 1'b0, req_ready0;
    logic [31:0] req_addr0 = '0, req_wdata0 = '0;
    logic        resp_valid0, resp_ready0 = 1'b1, resp_error0;
    logic [31:0] resp_rdata0;
    logic [1:0]  fsm_state0;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    d_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .fsm_state(fsm_state)
    );

    d_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid0), .req_write(req_write0), .req_addr(req_addr0),
        .req_wdata(req_wdata0), .req_ready(req_ready0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_error(resp_error0), .fsm_state(fsm_state0)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain word array plus the addressing rules.
    logic [31:0] ref_mem  [DEPTH];
    logic [31:0] ref0_mem [DEPTH];
    logic [32:0] exp_q[$];
    int          lat_q[$];
    int          hs_edge = 0;
    int          rr_mode = 2;

    function automatic bit addr_bad(input logic [31:0] addr);
        return (addr % 4 != 0) || ((addr / 4) >= DEPTH);
    endfunction

    always @(posedge clock) begin
        #1;
        case (rr_mode)
            0:       resp_ready = ($urandom_range(0, 3) != 0);
            1:       resp_ready = 1'b0;
            default: resp_ready = 1'b1;
        endcase
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input bit track, output int acc_edge);
        int          guard;
        bit          err;
        logic [31:0] rd;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
            req_valid = 1'b0;
            acc_edge  = -1;
            return;
        end
        acc_edge = cyc + 1;
        if (track) begin
            err = addr_bad(addr);
            rd  = 32'h0;
            if (!err) begin
                if (wr) ref_mem[addr / 4] = wd;
                else    rd = ref_mem[addr / 4];
            end
            exp_q.push_back({err, rd});
            lat_q.push_back(acc_edge);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || resp_valid) && g < 500) begin
            @(negedge clock);
            g++;
        end
        check("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor for the main instance: pops the scoreboard on each response transfer.
    logic        prev_valid = 1'b0;
    logic [31:0] prev_rdata = '0;
    logic        prev_err   = 1'b0;
    logic [32:0] e;
    int          a;

    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (resp_valid) begin
                if (!prev_valid) begin
                    if (lat_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_valid: got resp_valid=1, required 0 (no request pending)");
                    end else begin
                        a = lat_q.pop_front();
                        check("latency_edge", 32'(cyc), 32'(a + WS + 1));
                    end
                end else begin
                    check("hold_rdata", resp_rdata, prev_rdata);
                    check("hold_error", 32'(resp_error), 32'(prev_err));
                end
                check("busy_req_ready", 32'(req_ready), 32'd0);
                if (resp_ready) begin
                    hs_edge = cyc + 1;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_resp: got rdata %h err %b, required no response", resp_rdata, resp_error);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_rdata", resp_rdata, e[31:0]);
                        check("resp_error", 32'(resp_error), 32'(e[32]));
                    end
                end
            end
            prev_valid = resp_valid;
            prev_rdata = resp_rdata;
            prev_err   = resp_error;
        end
    end

    // Monitor for the zero-wait instance: expectations are pushed at each acceptance.
    logic        prev0 = 1'b0;
    logic [32:0] exp0_q[$];
    int          lat0_q[$];
    int          acc0_hist[$];
    logic [32:0] e0;
    bit          err0;
    logic [31:0] rd0;

    always @(negedge clock) begin
        if (reset) begin
            prev0 = 1'b0;
        end else begin
            if (req_valid0 && req_ready0) begin
                err0 = addr_bad(req_addr0);
                rd0  = 32'h0;
                if (!err0) begin
                    if (req_write0) ref0_mem[req_addr0 / 4] = req_wdata0;
                    else            rd0 = ref0_mem[req_addr0 / 4];
                end
                exp0_q.push_back({err0, rd0});
                lat0_q.push_back(cyc + 1);
                acc0_hist.push_back(cyc + 1);
            end
            if (resp_valid0 && !prev0) begin
                if (lat0_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w0_unexpected_valid: got resp_valid=1, required 0");
                end else begin
                    a = lat0_q.pop_front();
                    check("w0_latency_edge", 32'(cyc), 32'(a + 1));
                end
            end
            if (resp_valid0 && resp_ready0) begin
                if (exp0_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w0_unexpected_resp: got rdata %h, required no response", resp_rdata0);
                end else begin
                    e0 = exp0_q.pop_front();
                    check("w0_resp_rdata", resp_rdata0, e0[31:0]);
                    check("w0_resp_error", 32'(resp_error0), 32'(e0[32]));
                end
            end
            prev0 = resp_valid0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc_a, acc_b, kind;
        logic [31:0] addr;

        repeat (2) @(negedge clock);
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata,      32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_fsm_state",  32'(fsm_state),  32'd0);
        check("rst_w0_ready",   32'(req_ready0), 32'd1);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom, 1'b1, acc_a);
        wait_idle();

        issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b1, acc_a);
        issue(1'b0, 32'h10, 32'h0,        1'b1, acc_a);
        issue(1'b1, 32'h12, 32'h11111111, 1'b1, acc_a);
        issue(1'b0, 32'h10, 32'h0,        1'b1, acc_a);
        issue(1'b0, 32'h100, 32'h0,       1'b1, acc_a);
        issue(1'b1, 32'hFC, $urandom,     1'b1, acc_a);
        issue(1'b0, 32'hFC, 32'h0,        1'b1, acc_a);
        wait_idle();

        rr_mode = 1;
        issue(1'b0, 32'h10, 32'h0, 1'b1, acc_a);
        fork
            begin
                int g;
                g = 0;
                while (!resp_valid && g < 50) begin
                    @(negedge clock);
                    g++;
                end
                repeat (5) begin
                    @(negedge clock);
                    check("bp_req_ready", 32'(req_ready), 32'd0);
                    check("bp_resp_valid", 32'(resp_valid), 32'd1);
                end
                rr_mode = 2;
            end
            issue(1'b1, 32'h30, 32'hA5A50001, 1'b1, acc_b);
        join
        check("bp_accept_edge", 32'(acc_b), 32'(hs_edge + 1));
        wait_idle();

        rr_mode = 0;
        repeat (80) begin
            kind = $urandom_range(0, 9);
            if (kind == 0)      addr = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
            else if (kind == 1) addr = 32'($urandom_range(64, 4095)) * 32'd4;
            else                addr = 32'($urandom_range(0, 63)) * 32'd4;
            issue(1'($urandom_range(0, 1)), addr, $urandom, 1'b1, acc_a);
        end
        wait_idle();

        rr_mode = 2;
        issue(1'b1, 32'h20, 32'hCAFEF00D, 1'b0, acc_a);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("midrst_req_ready",  32'(req_ready),  32'd1);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_resp_rdata", resp_rdata,      32'd0);
        check("midrst_resp_error", 32'(resp_error), 32'd0);
        check("midrst_fsm_state",  32'(fsm_state),  32'd0);
        @(negedge clock);
        reset = 1'b0;
        issue(1'b0, 32'h20, 32'h0, 1'b1, acc_a);
        wait_idle();

        @(posedge clock);
        #1;
        req_valid0 = 1'b1;
        req_write0 = 1'b1;
        req_addr0  = 32'h04;
        req_wdata0 = 32'h12345678;
        @(posedge clock);
        #1 req_write0 = 1'b0;
        repeat (10) @(posedge clock);
        #1 req_valid0 = 1'b0;
        repeat (6) @(posedge clock);
        check("w0_accept_count", 32'(acc0_hist.size()), 32'd4);
        for (int i = 1; i < acc0_hist.size(); i++)
            check("w0_turnaround", 32'(acc0_hist[i] - acc0_hist[i-1]), 32'd3);
        check("w0_drain", 32'(exp0_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
